// File: rtl/nco_sweep_sequencer_pkg.sv
// Shared types and width constants for the NCO sweep sequencer.
// Optional build macro NCO_SWEEP_TAG_EN (step tag in the upper bits of each
// memory word) is consumed by nco_sweep_mem_writer.
package nco_sweep_pkg;

  localparam int NCO_IN_W  = 32;
  localparam int NCO_OUT_W = 36;
  localparam int MEM_AW    = 14;
  localparam int MEM_DW    = 64;
  localparam int MEM_BE_W  = MEM_DW / 8;
  localparam int STEP_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/nco_sweep_sequencer_if.sv
// Memory s2 slave-port bundle. The sequencer drives it as master; the
// on-chip memory (or a bench) observes it as slave.
interface nco_sweep_mem_if
  import nco_sweep_pkg::*;
  ();

  logic [MEM_AW-1:0]   address;
  logic                chipselect;
  logic                clken;
  logic                write;
  logic [MEM_DW-1:0]   writedata;
  logic [MEM_BE_W-1:0] byteenable;

  modport master (
    output address, chipselect, clken, write, writedata, byteenable
  );

  modport slave (
    input address, chipselect, clken, write, writedata, byteenable
  );

endinterface

// File: rtl/nco_sweep_mem_writer.sv
// Registered s2 write stage with the capture address pointer and overflow
// detection. The pointer stops at the top word and never wraps; once that
// word has been written, any further write request is dropped and flags
// overflow. Build macro NCO_SWEEP_TAG_EN puts the step index in [63:48].
module nco_sweep_mem_writer
  import nco_sweep_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [MEM_AW-1:0]    base_addr,
  input  logic                 wr_req,
  input  logic [NCO_OUT_W-1:0] sample,
  input  logic [STEP_W-1:0]    step_idx,
  output logic                 full,
  output logic                 overflow,
  nco_sweep_mem_if.master      mem
);

  logic [MEM_AW-1:0] ptr;
  logic [MEM_DW-1:0] wdata;

`ifdef NCO_SWEEP_TAG_EN
  // Tag each word with its step so software can split the capture buffer.
  always_comb begin
    wdata = {step_idx, {(MEM_DW - STEP_W - NCO_OUT_W){1'b0}}, sample};
  end
`else
  logic unused_step_idx;
  assign unused_step_idx = ^step_idx;

  // Plain zero-extended sample.
  always_comb begin
    wdata = {{(MEM_DW - NCO_OUT_W){1'b0}}, sample};
  end
`endif

  // Write strobes are single-cycle; address/data hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= '0;
      full           <= 1'b0;
      overflow       <= 1'b0;
      mem.address    <= '0;
      mem.chipselect <= 1'b0;
      mem.clken      <= 1'b0;
      mem.write      <= 1'b0;
      mem.writedata  <= '0;
      mem.byteenable <= '0;
    end else begin
      mem.chipselect <= 1'b0;
      mem.clken      <= 1'b0;
      mem.write      <= 1'b0;
      mem.byteenable <= '0;
      if (load) begin
        ptr      <= base_addr;
        full     <= 1'b0;
        overflow <= 1'b0;
      end else if (wr_req) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          mem.address    <= ptr;
          mem.writedata  <= wdata;
          mem.byteenable <= '1;
          mem.chipselect <= 1'b1;
          mem.clken      <= 1'b1;
          mem.write      <= 1'b1;
          if (ptr == '1) full <= 1'b1;
          else           ptr  <= ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nco_sweep_sequencer.sv
// NCO frequency-sweep sequencer: per step, loads a phase increment, discards
// settling samples, then captures samples into memory via the s2 port.
// Build macro NCO_SWEEP_TAG_EN (see nco_sweep_mem_writer) tags words by step.
//
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | nco_in_valid strobe with current increment
//   SETTLE  | discarding SETTLE_SAMPLES samples
//   CAPTURE | forwarding samples to the memory writer
//   NEXT    | advance increment, count down steps
//   DONE    | one-cycle done pulse
module nco_sweep_sequencer
  import nco_sweep_pkg::*;
#(
  parameter int SETTLE_SAMPLES = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NCO_IN_W-1:0]  phase_inc,
  input  logic [NCO_IN_W-1:0]  phase_step,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic [MEM_AW-1:0]    samples_per_step,
  input  logic [MEM_AW-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 nco_in_valid,
  output logic [NCO_IN_W-1:0]  nco_in_data,
  input  logic [NCO_OUT_W-1:0] nco_out_data,
  input  logic                 nco_out_valid,
  nco_sweep_mem_if.master      mem
);

  localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);

  state_t              state;
  logic [NCO_IN_W-1:0] inc;
  logic [NCO_IN_W-1:0] step;
  logic [STEP_W-1:0]   steps_left;
  logic [STEP_W-1:0]   step_idx;
  logic [MEM_AW-1:0]   spp;
  logic [MEM_AW-1:0]   cap_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                accept;
  logic                wr_req;
  logic                full;

  assign accept = (state == IDLE) && start;
  // A sample arriving with abort is dropped so no strobe follows an abort.
  assign wr_req = (state == CAPTURE) && nco_out_valid && !abort;

  // Sweep controller; outputs are registered alongside the state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      inc          <= '0;
      step         <= '0;
      steps_left   <= '0;
      step_idx     <= '0;
      spp          <= '0;
      cap_cnt      <= '0;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      nco_in_valid <= 1'b0;
      nco_in_data  <= '0;
    end else if (abort && state != IDLE) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      nco_in_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            inc        <= phase_inc;
            step       <= phase_step;
            steps_left <= num_steps;
            spp        <= samples_per_step;
            step_idx   <= '0;
            busy       <= 1'b1;
            if (num_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= LOAD;
              nco_in_valid <= 1'b1;
              nco_in_data  <= phase_inc;
            end
          end
        end
        LOAD: begin
          nco_in_valid <= 1'b0;
          settle_cnt   <= SETTLE_W'(SETTLE_SAMPLES);
          state        <= SETTLE;
        end
        SETTLE: begin
          if (nco_out_valid) begin
            settle_cnt <= settle_cnt - 1'b1;
            if (settle_cnt == SETTLE_W'(1)) begin
              cap_cnt <= spp;
              state   <= (spp == '0) ? NEXT : CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (nco_out_valid) begin
            if (full) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cap_cnt <= cap_cnt - 1'b1;
              if (cap_cnt == MEM_AW'(1)) state <= NEXT;
            end
          end
        end
        NEXT: begin
          inc        <= inc + step;
          steps_left <= steps_left - 1'b1;
          step_idx   <= step_idx + 1'b1;
          if (steps_left == STEP_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= LOAD;
            nco_in_valid <= 1'b1;
            nco_in_data  <= inc + step;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nco_sweep_mem_writer u_writer (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .load      (accept),
    .base_addr (base_addr),
    .wr_req    (wr_req),
    .sample    (nco_out_data),
    .step_idx  (step_idx),
    .full      (full),
    .overflow  (overflow),
    .mem       (mem)
  );

endmodule

// File: doc/nco_sweep_sequencer.md
Name: nco_sweep_sequencer

Overview:
Sequences the NCO through a frequency sweep and captures its output into on-chip memory through the memory's second (s2) slave port.
- For each sweep step: loads a phase increment into the NCO, discards settling samples, then writes a fixed number of output samples to consecutive memory words.
- Sits beside the system interconnect and is started and monitored by host/PIO-level control.

Parameters:
- SETTLE_SAMPLES, 8, NCO output samples discarded after each phase-increment load
- MEM_AW, 14, memory word address width
- MEM_DW, 64, memory data width
- NCO_IN_W, 32, phase-increment width
- NCO_OUT_W, 36, NCO output sample width

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle sweep request, accepted only in IDLE
- abort  in  1  cancel sweep
- phase_inc  in  32  initial phase increment, sampled at start
- phase_step  in  32  increment added per step (two's-complement wrap), sampled at start
- num_steps  in  16  number of sweep steps, sampled at start
- samples_per_step  in  14  words captured per step, sampled at start
- base_addr  in  14  first memory word address, sampled at start
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse at sweep completion
- overflow  out  1  sticky; address space exhausted; cleared by next accepted start
- nco_in_valid  out  1  phase-increment load strobe
- nco_in_data  out  32  phase increment
- nco_out_data  in  36  NCO sample
- nco_out_valid  in  1  sample valid
- mem_address  out  14  s2 address
- mem_chipselect  out  1  s2 chipselect
- mem_clken  out  1  s2 clock enable
- mem_write  out  1  s2 write
- mem_writedata  out  64  s2 write data
- mem_byteenable  out  8  s2 byte enable

Behaviour:
- Reset: all outputs 0; state IDLE; pointer, counters and overflow cleared. Reset mid-sweep abandons the sweep with no done pulse.
- IDLE:
  - start=1 latches all inputs; pointer=base_addr; overflow cleared; next state LOAD.
  - start with num_steps=0: pulse done the next cycle and return to IDLE; no NCO load.
- LOAD: nco_in_valid=1 for exactly one cycle with nco_in_data=current increment; next state SETTLE.
- SETTLE: count nco_out_valid pulses; after SETTLE_SAMPLES of them, go to CAPTURE, or to NEXT if samples_per_step=0.
- CAPTURE: each nco_out_valid produces a registered write in the following cycle:
  - mem_write, mem_chipselect and mem_clken all =1;
  - mem_address=pointer; mem_writedata={28'b0, sample}; mem_byteenable=8'hFF;
  - pointer increments after each write.
  - After the write for the samples_per_step-th sample, go to NEXT.
  - s2 has no wait state, so one write per cycle is sustained.
- NEXT: increment += phase_step; steps remaining -1; if steps remain go to LOAD, else go to DONE.
- DONE: done=1 for one cycle; then IDLE. busy deasserts in the IDLE cycle.
- Overflow: a write to address 2^MEM_AW-1 is the last allowed write. A further capture sample sets overflow, suppresses that write, and goes to DONE. The pointer never wraps.
- abort=1 in any non-IDLE state: next cycle is IDLE, write strobes low, no done pulse. abort has priority over start in the same cycle.
- start while busy is ignored.
- nco_out_valid outside SETTLE/CAPTURE is ignored.
- mem_write, mem_chipselect and mem_clken are low whenever no write is issued.

Optional Feature:
- NCO_SWEEP_TAG_EN defined: mem_writedata[63:48] = zero-based step index and [47:36]=0, so software can identify the step of each word.
- Undefined: bits [63:36] are always 0.

Decomposition:
- Package nco_sweep_pkg: state enum (IDLE, LOAD, SETTLE, CAPTURE, NEXT, DONE) and width constants (NCO_IN_W=32, NCO_OUT_W=36, MEM_AW=14, MEM_DW=64, STEP_W=16).
- Sub-module nco_sweep_mem_writer: registered s2 write stage plus address pointer and overflow detection. The top level holds the FSM and counters.

Test Plan:
- Basic sweep:
  - Stimulus: phase_inc=0x0100_0000, phase_step=0x0010_0000, num_steps=3, samples_per_step=4, base_addr=0x0100, NCO valid every cycle.
  - Response: three nco_in_valid pulses with 0x01000000, 0x01100000, 0x01200000; 12 writes to 0x0100–0x010B; done one cycle; busy low afterwards.
- Sparse valid:
  - Stimulus: nco_out_valid every 3rd cycle, num_steps=1, samples_per_step=2.
  - Response: exactly SETTLE_SAMPLES=8 samples discarded, then 2 writes, each one cycle after its valid.
- Overflow:
  - Stimulus: base_addr=0x3FFE, samples_per_step=5.
  - Response: writes to 0x3FFE and 0x3FFF only; overflow=1; done pulse; next start clears overflow.
- Abort:
  - Stimulus: abort asserted during the 2nd CAPTURE write of step 1.
  - Response: IDLE next cycle; no further writes; no done pulse; busy=0.
- Edge starts:
  - num_steps=0 -> done one cycle after start, no nco_in_valid.
  - start asserted while busy -> no change.
  - Async reset mid-CAPTURE -> all outputs 0 immediately.
- Tag feature:
  - With NCO_SWEEP_TAG_EN, step 2 words carry [63:48]=0x0002.
  - Without it, [63:36]=0.
